// File: rtl/arith_pkg.sv
// Shared arithmetic-demo definitions: default operand width and the divider's state encoding.
package arith_pkg;

  localparam int ARITH_WIDTH = 3;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_RUN  = 2'd1,
    DIV_DONE = 2'd2
  } div_state_t;

endpackage

// File: rtl/divider_datapath.sv
// Restoring-divider datapath: partial remainder R, shifting dividend/quotient Q, divisor D,
// iteration counter P and the trial subtractor. Reports Zbit (last iteration) and borrow to the FSM.
module divider_datapath #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             zbit,
  output logic             borrow,
  output logic [WIDTH-2:0] q_low,
  output logic [WIDTH-1:0] r_out
);

  localparam int PW = $clog2(WIDTH + 1);

  logic [WIDTH:0]   r;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] d;
  logic [PW-1:0]    p;

  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] trial;
  logic [WIDTH:0]   r_next;
  logic [WIDTH-1:0] q_next;

  assign shifted = {r[WIDTH-1:0], q[WIDTH-1]};
  assign trial   = {1'b0, shifted} - {2'b00, d};
  // A set top bit of R would mean the shifted value already exceeds any divisor, so it can never borrow.
  assign borrow  = trial[WIDTH+1] & ~r[WIDTH];
  assign r_next  = borrow ? shifted : trial[WIDTH:0];
  assign q_next  = {q[WIDTH-2:0], ~borrow};

  assign zbit  = (p == PW'(1));
  assign q_low = q[WIDTH-2:0];
  assign r_out = r_next[WIDTH-1:0];

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r <= '0;
      q <= '0;
      d <= '0;
      p <= '0;
    end else if (load) begin
      r <= '0;
      q <= dividend;
      d <= divisor;
      p <= PW'(WIDTH);
    end else if (shift) begin
      r <= r_next;
      q <= q_next;
      p <= p - 1'b1;
    end
  end

endmodule

// File: rtl/binary_divider.sv
// Unsigned restoring shift-subtract divider, one quotient bit per clock, one-cycle done pulse.
// Optional feature macro DIVIDER_ZERO_CHECK_EN: divide-by-zero short-cut with div_by_zero flag.
module binary_divider
  import arith_pkg::*;
#(
  parameter int WIDTH = ARITH_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  div_state_t       state, state_next;
  logic             accept;
  logic             div_zero;
  logic             shift;
  logic             zbit;
  logic             borrow;
  logic [WIDTH-2:0] q_low;
  logic [WIDTH-1:0] r_out;
  logic             dz_q;

  assign accept = start && (state == DIV_IDLE || state == DIV_DONE);
  assign shift  = (state == DIV_RUN);

`ifdef DIVIDER_ZERO_CHECK_EN
  assign div_zero = (divisor == '0);
`else
  assign div_zero = 1'b0;
`endif

  divider_datapath #(.WIDTH(WIDTH)) u_datapath (
    .clk      (clk),
    .reset    (reset),
    .load     (accept),
    .shift    (shift),
    .dividend (dividend),
    .divisor  (divisor),
    .zbit     (zbit),
    .borrow   (borrow),
    .q_low    (q_low),
    .r_out    (r_out)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= DIV_IDLE;
    else       state <= state_next;
  end

  // NOTE: state_next is defaulted before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_next = state;
    case (state)
      DIV_IDLE: if (accept) state_next = div_zero ? DIV_DONE : DIV_RUN;
      DIV_RUN:  if (zbit)   state_next = DIV_DONE;
      DIV_DONE: begin
        if (accept) state_next = div_zero ? DIV_DONE : DIV_RUN;
        else        state_next = DIV_IDLE;
      end
      default:  state_next = DIV_IDLE;
    endcase
  end

  // Results change only on the edge that enters DONE; the last quotient bit comes straight from the final trial.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      quotient  <= '0;
      remainder <= '0;
      dz_q      <= 1'b0;
    end else if (accept && div_zero) begin
      quotient  <= '1;
      remainder <= dividend;
      dz_q      <= 1'b1;
    end else if (accept) begin
      dz_q      <= 1'b0;
    end else if (shift && zbit) begin
      quotient  <= {q_low, ~borrow};
      remainder <= r_out;
    end
  end

  assign busy        = (state == DIV_RUN);
  assign done        = (state == DIV_DONE);
  assign div_by_zero = dz_q;

endmodule
